// File: rtl/ghost_position_unit.sv
// Ghost tile-position register: steps every TICK_DIV cycles, wall-checks the control stage's
// candidate, commits or blocks it, and detects Pac-Man contact. Optional GHOST_TUNNEL_WRAP_EN.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 24
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 32
`endif

module ghost_position_unit #(
  parameter int TICK_DIV = 20000000,
  parameter int TILE     = 20,
  parameter int START_X  = 280,
  parameter int START_Y  = 240
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [$clog2(`WIDTH)-1:0]                 ctrl_next_x,
  input  logic [$clog2(`HEIGHT)-1:0]                ctrl_next_y,
  input  logic [`TILE_ROW_NUM*`TILE_COL_NUM-1:0]    tilemap_walls,
  input  logic [$clog2(`WIDTH)-1:0]                 pacman_x,
  input  logic [$clog2(`HEIGHT)-1:0]                pacman_y,
  input  logic                                      respawn,
  output logic [$clog2(`WIDTH)-1:0]                 x,
  output logic [$clog2(`HEIGHT)-1:0]                y,
  output logic                                      step,
  output logic                                      blocked,
  output logic                                      caught
);
  localparam int XW = $clog2(`WIDTH);
  localparam int YW = $clog2(`HEIGHT);
  localparam int CW = $clog2(TICK_DIV);
  localparam int NT = `TILE_ROW_NUM * `TILE_COL_NUM;
  localparam int IW = $clog2(NT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_COMMIT, S_CAUGHT} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [XW-1:0] cand_x, wx, px;
  logic [YW-1:0] cand_y, py;
  logic          legal, legal_d, in_range, aligned, wall;
  logic [IW-1:0] widx;
  int            cx, cy;

  // Candidate legality, evaluated during CHECK and registered at its edge
  always_comb begin
    wx = ctrl_next_x;
`ifdef GHOST_TUNNEL_WRAP_EN
    if (32'(ctrl_next_x) >= `WIDTH)
      wx = (x == '0) ? XW'(`WIDTH - TILE) : '0;
`endif
    cx       = 32'(wx);
    cy       = 32'(ctrl_next_y);
    in_range = (cx < `WIDTH) && (cy < `HEIGHT);
    aligned  = ((cx % TILE) == 0) && ((cy % TILE) == 0);
    widx     = IW'((cy / TILE) * `TILE_COL_NUM + (cx / TILE));
    wall     = in_range ? tilemap_walls[widx] : 1'b0;
    legal_d  = in_range && aligned && !wall;
  end

  // Position that COMMIT leaves behind, used for its contact check
  assign px = legal ? cand_x : x;
  assign py = legal ? cand_y : y;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (enable) state_nx = S_WAIT;
      S_WAIT: begin
        if (x == pacman_x && y == pacman_y)        state_nx = S_CAUGHT;
        else if (enable && cnt == CW'(TICK_DIV-1)) state_nx = S_CHECK;
      end
      S_CHECK:  state_nx = S_COMMIT;
      S_COMMIT: state_nx = (px == pacman_x && py == pacman_y) ? S_CAUGHT : S_WAIT;
      S_CAUGHT: if (respawn) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign caught = (state == S_CAUGHT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      x       <= XW'(START_X);
      y       <= YW'(START_Y);
      cand_x  <= '0;
      cand_y  <= '0;
      legal   <= 1'b0;
      step    <= 1'b0;
      blocked <= 1'b0;
    end else begin
      step    <= 1'b0;
      blocked <= 1'b0;
      case (state)
        S_WAIT: begin
          if (state_nx != S_WAIT) cnt <= '0;
          else if (enable)        cnt <= cnt + CW'(1);
        end
        S_CHECK: begin
          cand_x <= wx;
          cand_y <= ctrl_next_y;
          legal  <= legal_d;
        end
        S_COMMIT: begin
          if (legal) begin
            x    <= cand_x;
            y    <= cand_y;
            step <= 1'b1;
          end else begin
            blocked <= 1'b1;
          end
        end
        S_CAUGHT: begin
          if (respawn) begin
            x <= XW'(START_X);
            y <= YW'(START_Y);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ghost_position_unit.sv
// Directed bench for ghost_position_unit with TICK_DIV=4 on a 640x480 / 32x24-tile grid.
module tb_ghost_position_unit;
  logic         clk = 1'b0;
  logic         reset, enable, respawn;
  logic [9:0]   ctrl_next_x, pacman_x, x;
  logic [8:0]   ctrl_next_y, pacman_y, y;
  logic [767:0] walls;
  logic         step, blocked, caught;
  int           total = 0;
  int           bad   = 0;
  int           n;

  ghost_position_unit #(.TICK_DIV(4), .TILE(20), .START_X(280), .START_Y(240)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ctrl_next_x(ctrl_next_x), .ctrl_next_y(ctrl_next_y),
    .tilemap_walls(walls), .pacman_x(pacman_x), .pacman_y(pacman_y),
    .respawn(respawn), .x(x), .y(y), .step(step), .blocked(blocked), .caught(caught)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(step || blocked) && cyc < 50);
    if (!(step || blocked)) chk("timeout", 0, 1);
  endtask

  task automatic set_ctrl(input int cx, input int cy);
    ctrl_next_x = 10'(cx);
    ctrl_next_y = 9'(cy);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; respawn = 1'b0; walls = '0;
    set_ctrl(0, 0);
    pacman_x = 10'd620; pacman_y = 9'd460;
    tick(); tick();
    reset = 1'b0;
    chk("rst_x", x, 280);
    chk("rst_y", y, 240);
    chk("rst_step", step, 0);
    chk("rst_blocked", blocked, 0);
    chk("rst_caught", caught, 0);

    // first step: IDLE->WAIT on edge 0, commit visible after edge 6
    set_ctrl(260, 240);
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) tick();
    chk("step_early", step, 0);
    tick();
    chk("step_c6", step, 1);
    chk("step_x", x, 260);
    chk("step_y", y, 240);
    chk("step_noblk", blocked, 0);
    tick();
    chk("step_1cyc", step, 0);

    // move back, then hit wall tile (13,12)
    set_ctrl(280, 240);
    wait_pulse(n);
    chk("back_step", step, 1);
    chk("back_x", x, 280);
    walls[397] = 1'b1;
    set_ctrl(260, 240);
    wait_pulse(n);
    chk("wall_period", n, 6);
    chk("wall_blk", blocked, 1);
    chk("wall_nostep", step, 0);
    chk("wall_x", x, 280);
    chk("wall_y", y, 240);
    tick();
    chk("wall_1cyc", blocked, 0);
    wait_pulse(n);
    chk("retry_blk", blocked, 1);
    walls[397] = 1'b0;
    wait_pulse(n);
    chk("clear_step", step, 1);
    chk("clear_x", x, 260);

    // misaligned and y out of range
    set_ctrl(265, 240);
    wait_pulse(n);
    chk("misal_blk", blocked, 1);
    chk("misal_x", x, 260);
    set_ctrl(260, 500);
    wait_pulse(n);
    chk("yrange_blk", blocked, 1);
    chk("yrange_y", y, 240);

    // pause 10 cycles mid-WAIT: 4 more cycles after resume instead of 4-10
    set_ctrl(280, 240);
    tick(); tick();
    enable = 1'b0;
    repeat (10) tick();
    chk("pause_hold", step, 0);
    enable = 1'b1;
    wait_pulse(n);
    chk("pause_cyc", n, 4);
    chk("pause_step", step, 1);
    chk("pause_x", x, 280);

    // tunnel from x=0 with an off-grid candidate
    set_ctrl(0, 240);
    wait_pulse(n);
    chk("edge_x", x, 0);
    set_ctrl(1004, 240);
    wait_pulse(n);
`ifdef GHOST_TUNNEL_WRAP_EN
    chk("tunnel_step", step, 1);
    chk("tunnel_x", x, 620);
`else
    chk("tunnel_blk", blocked, 1);
    chk("tunnel_x", x, 0);
`endif
    set_ctrl(260, 240);
    wait_pulse(n);
    chk("ret_x", x, 260);

    // contact during WAIT, held in CAUGHT, then respawn
    tick(); tick();
    pacman_x = 10'd260; pacman_y = 9'd240;
    tick();
    chk("caught_rise", caught, 1);
    chk("caught_x", x, 260);
    set_ctrl(280, 240);
    repeat (8) tick();
    chk("caught_hold", caught, 1);
    chk("caught_nostep", step, 0);
    chk("caught_hold_x", x, 260);
    pacman_x = 10'd620; pacman_y = 9'd460;
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    chk("resp_caught", caught, 0);
    chk("resp_x", x, 280);
    chk("resp_y", y, 240);
    set_ctrl(260, 240);
    wait_pulse(n);
    chk("resp_idle_cyc", n, 7);
    chk("resp_step_x", x, 260);

    // reset during CHECK aborts the step
    set_ctrl(300, 240);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rck_x", x, 280);
    chk("rck_y", y, 240);
    chk("rck_step", step, 0);
    chk("rck_blk", blocked, 0);
    chk("rck_caught", caught, 0);
    enable = 1'b0;
    repeat (8) tick();
    chk("rck_nocommit_x", x, 280);
    chk("rck_nocommit_step", step, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
